// File: rtl/mixer_seq_pkg.sv
// Shared constants for the mixer power sequencer: register map, CTRL bit positions
// and the FSM state encoding visible through STATUS.
package mixer_seq_pkg;

  localparam int unsigned MIXSEQ_ADDR_W = 3;

  localparam logic [MIXSEQ_ADDR_W-1:0] ADDR_CTRL   = 3'd0;
  localparam logic [MIXSEQ_ADDR_W-1:0] ADDR_T1     = 3'd1;
  localparam logic [MIXSEQ_ADDR_W-1:0] ADDR_T2     = 3'd2;
  localparam logic [MIXSEQ_ADDR_W-1:0] ADDR_BSEL   = 3'd3;
  localparam logic [MIXSEQ_ADDR_W-1:0] ADDR_STATUS = 3'd4;

  localparam int unsigned CTRL_UP_BIT   = 0;
  localparam int unsigned CTRL_DOWN_BIT = 1;

  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StUpPd  = 3'd1,
    StUpOta = 3'd2,
    StOn    = 3'd3,
    StDnBuf = 3'd4,
    StDnOta = 3'd5
  } state_e;

  // Busy while a timed transition is in progress.
  function automatic logic is_busy(state_e s);
    return !(s == StOff || s == StOn);
  endfunction

endpackage

// File: rtl/mixer_seq_timer.sv
// Loadable saturating down-counter that times the settling gap of each sequencer step.
module mixer_seq_timer #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  output logic [CntW-1:0] value_o,
  output logic            zero_o
);

  logic [CntW-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = load_val_i;
    end else if (value_q != '0) begin
      value_d = value_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/mixer_seq.sv
// Timed power-up/down sequencer for the mixer pd/ota/buff pins, programmed over a
// simple valid/ready register bus.
module mixer_seq
  import mixer_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid,
  input  logic [MIXSEQ_ADDR_W-1:0] address,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     wstrb,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ready,
  output logic                     done,
  output logic                     pd,
  output logic                     ota,
  output logic [1:0]               buff
);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  t1_d, t1_q, t2_d, t2_q;
  logic [1:0]        bsel_d, bsel_q;
  logic              pd_d, pd_q, ota_d, ota_q, done_d, done_q, ready_q;
  logic [1:0]        buff_d, buff_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  logic             wr, rd, cmd_up, cmd_dn, up_only, bsel_wr;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val, tmr_value_unused;
  logic             unused_wdata;

  assign wr      = valid & wstrb;
  assign rd      = valid & ~wstrb;
  assign cmd_up  = wr && (address == ADDR_CTRL) && wdata[CTRL_UP_BIT];
  assign cmd_dn  = wr && (address == ADDR_CTRL) && wdata[CTRL_DOWN_BIT];
  assign up_only = cmd_up & ~cmd_dn;
  assign bsel_wr = wr && (address == ADDR_BSEL);

  assign unused_wdata = ^wdata[DATA_W-1:CNT_W];

  mixer_seq_timer #(
    .CntW(CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .value_o    (tmr_value_unused),
    .zero_o     (tmr_zero)
  );

  // Register file and read path.
  always_comb begin
    t1_d    = t1_q;
    t2_d    = t2_q;
    bsel_d  = bsel_q;
    rdata_d = '0;
    if (wr && address == ADDR_T1) t1_d = wdata[CNT_W-1:0];
    if (wr && address == ADDR_T2) t2_d = wdata[CNT_W-1:0];
    if (bsel_wr)                  bsel_d = wdata[1:0];
    if (rd) begin
      case (address)
        ADDR_T1:     rdata_d = DATA_W'(t1_q);
        ADDR_T2:     rdata_d = DATA_W'(t2_q);
        ADDR_BSEL:   rdata_d = DATA_W'(bsel_q);
        ADDR_STATUS: rdata_d = DATA_W'({is_busy(state_q), state_q});
        default:     rdata_d = '0;
      endcase
    end
  end

  // Sequencer FSM; commands take priority over timer expiry in the same cycle.
  always_comb begin
    state_d  = state_q;
    pd_d     = pd_q;
    ota_d    = ota_q;
    buff_d   = buff_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = t1_q;
    unique case (state_q)
      StOff: begin
        if (up_only) begin
          state_d  = StUpPd;
          pd_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = t1_q;
        end
      end
      StUpPd: begin
        if (cmd_dn) begin
          state_d  = StDnOta;
          tmr_load = 1'b1;
          tmr_val  = t1_q;
        end else if (tmr_zero) begin
          state_d  = StUpOta;
          ota_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = t2_q;
        end
      end
      StUpOta: begin
        if (cmd_dn) begin
          state_d  = StDnBuf;
          tmr_load = 1'b1;
          tmr_val  = t2_q;
        end else if (tmr_zero) begin
          state_d = StOn;
          buff_d  = bsel_d;
          done_d  = 1'b1;
        end
      end
      StOn: begin
        if (cmd_dn) begin
          state_d  = StDnBuf;
          buff_d   = 2'd0;
          tmr_load = 1'b1;
          tmr_val  = t2_q;
        end else if (bsel_wr) begin
          buff_d = wdata[1:0];
        end
      end
      StDnBuf: begin
        if (up_only) begin
          state_d  = StUpOta;
          tmr_load = 1'b1;
          tmr_val  = t2_q;
        end else if (tmr_zero) begin
          state_d  = StDnOta;
          ota_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = t1_q;
        end
      end
      StDnOta: begin
        if (up_only) begin
          state_d  = StUpPd;
          tmr_load = 1'b1;
          tmr_val  = t1_q;
        end else if (tmr_zero) begin
          state_d = StOff;
          pd_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StOff;
        pd_d    = 1'b1;
        ota_d   = 1'b0;
        buff_d  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StOff;
      t1_q    <= '0;
      t2_q    <= '0;
      bsel_q  <= 2'd0;
      pd_q    <= 1'b1;
      ota_q   <= 1'b0;
      buff_q  <= 2'd0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      bsel_q  <= bsel_d;
      pd_q    <= pd_d;
      ota_q   <= ota_d;
      buff_q  <= buff_d;
      done_q  <= done_d;
      ready_q <= valid;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign done  = done_q;
  assign pd    = pd_q;
  assign ota   = ota_q;
  assign buff  = buff_q;

endmodule
